// File: rtl/sha1_msg_sequencer_if.sv
// Message word stream into the SHA-1 sequencer.
// Word accepted when s_valid & s_ready; s_last_bytes 0 means 4 bytes.
interface sha1_msg_sequencer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [1:0]  s_last_bytes;
    logic        s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        output s_last_bytes,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        input  s_last_bytes,
        output s_ready
    );
endinterface

// File: rtl/sha1_msg_sequencer.sv
// SHA-1 front end: packs big-endian words into 512-bit chunks,
// applies padding plus 64-bit bit length, sequences the core.
module sha1_msg_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sha1_msg_sequencer_if.slave  s,
    output logic                 core_init,
    output logic                 core_next,
    output logic [511:0]         core_chunk,
    input  logic                 core_ready,
    input  logic [159:0]         core_digest,
    output logic [159:0]         digest,
    output logic                 digest_valid,
    output logic                 busy
);

    typedef enum logic [2:0] {
        LOAD,
        PAD,
        ISSUE,
        SETTLE,
        WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       word_idx_q, word_idx_d;
    logic [LEN_W-1:0] msg_bytes_q, msg_bytes_d;
    logic             first_block_q, first_block_d;
    logic             len_pending_q, len_pending_d;
    logic             pad80_q, pad80_d;
    logic             msg_end_q, msg_end_d;
    logic             s_ready_q, s_ready_d;
    logic             digest_valid_q, digest_valid_d;
    logic [159:0]     digest_q, digest_d;
    logic [31:0]      buf_q [16];
    logic [31:0]      buf_d [16];

    logic             accept;
    logic [2:0]       last_k;
    logic [31:0]      last_word;
    logic [63:0]      bit_len;
    logic [3:0]       widx;

    assign accept  = s.s_valid & s_ready_q;
    assign bit_len = 64'(msg_bytes_q) << 3;
    assign widx    = word_idx_q[3:0];
    assign last_k  = (s.s_last_bytes == 2'd0) ? 3'd4 : {1'b0, s.s_last_bytes};

    // Partial last word: keep the valid bytes, 0x80 right after them
    always_comb begin
        unique case (s.s_last_bytes)
            2'd1:    last_word = {s.s_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {s.s_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {s.s_data[31:8], 8'h80};
            default: last_word = s.s_data;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        word_idx_d     = word_idx_q;
        msg_bytes_d    = msg_bytes_q;
        first_block_d  = first_block_q;
        len_pending_d  = len_pending_q;
        pad80_d        = pad80_q;
        msg_end_d      = msg_end_q;
        digest_valid_d = digest_valid_q;
        digest_d       = digest_q;
        buf_d          = buf_q;
        core_init      = 1'b0;
        core_next      = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    digest_valid_d = 1'b0;
                    word_idx_d     = word_idx_q + 5'd1;
                    if (s.s_last) begin
                        buf_d[widx] = last_word;
                        msg_bytes_d = msg_bytes_q + LEN_W'(last_k);
                        pad80_d     = (s.s_last_bytes == 2'd0);
                        msg_end_d   = 1'b1;
                        state_d     = PAD;
                    end else begin
                        buf_d[widx] = s.s_data;
                        msg_bytes_d = msg_bytes_q + LEN_W'(4);
                        if (word_idx_q == 5'd15) begin
                            len_pending_d = 1'b0;
                            state_d       = ISSUE;
                        end
                    end
                end
            end
            PAD: begin
                // Index 16 means the chunk filled before the length fit
                if (word_idx_q == 5'd16) begin
                    len_pending_d = 1'b0;
                    state_d       = ISSUE;
                end else if (pad80_q) begin
                    buf_d[widx] = 32'h8000_0000;
                    word_idx_d  = word_idx_q + 5'd1;
                    pad80_d     = 1'b0;
                end else if (word_idx_q == 5'd14) begin
                    buf_d[14]     = bit_len[63:32];
                    buf_d[15]     = bit_len[31:0];
                    len_pending_d = 1'b1;
                    state_d       = ISSUE;
                end else begin
                    buf_d[widx] = 32'h0;
                    word_idx_d  = word_idx_q + 5'd1;
                end
            end
            ISSUE: begin
                core_init     = first_block_q;
                core_next     = ~first_block_q;
                first_block_d = 1'b0;
                state_d       = SETTLE;
            end
            SETTLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (core_ready) begin
                    word_idx_d = 5'd0;
                    if (len_pending_q) begin
                        digest_d       = core_digest;
                        digest_valid_d = 1'b1;
                        msg_bytes_d    = '0;
                        first_block_d  = 1'b1;
                        len_pending_d  = 1'b0;
                        msg_end_d      = 1'b0;
                        state_d        = LOAD;
                    end else begin
                        buf_d   = '{default: '0};
                        state_d = msg_end_q ? PAD : LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign s_ready_d = (state_d == LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= LOAD;
            word_idx_q     <= 5'd0;
            msg_bytes_q    <= '0;
            first_block_q  <= 1'b1;
            len_pending_q  <= 1'b0;
            pad80_q        <= 1'b0;
            msg_end_q      <= 1'b0;
            s_ready_q      <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
            buf_q          <= '{default: '0};
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            msg_bytes_q    <= msg_bytes_d;
            first_block_q  <= first_block_d;
            len_pending_q  <= len_pending_d;
            pad80_q        <= pad80_d;
            msg_end_q      <= msg_end_d;
            s_ready_q      <= s_ready_d;
            digest_valid_q <= digest_valid_d;
            digest_q       <= digest_d;
            buf_q          <= buf_d;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_chunk
        assign core_chunk[511-32*i -: 32] = buf_q[i];
    end

    assign s.s_ready    = s_ready_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = (state_q != LOAD) || (word_idx_q != 5'd0);

endmodule
